seq_checker: RTL

Stream receiver and checker for incrementing counter sequences, e.g. block-counter values produced by a counter source. It accepts beats over a valid/ready handshake and compares each beat against an internally tracked expected value. It reports completion, a saturating mismatch count, and the index and data of the first mismatch. It sits in the util test infrastructure downstream of any counter or sequence producer.

---
 rtl/seq_checker.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/seq_checker.sv
// -----------------------------------------------------------------------------
// seq_checker
//
// Stream receiver that checks an incrementing counter sequence. A start pulse
// loads the first expected value and the run length; every accepted beat is
// compared against the internally tracked expected value. Reports completion,
// a saturating mismatch count, and the index/data of the first mismatch.
//
// Build option:
//   SEQ_CHECKER_WRAP_EN  defined   -> expected value wraps 2^WIDTH-1 -> 0,
//                                     overflow is constant 0.
//                        undefined -> an accept at expected == 2^WIDTH-1 sets
//                                     the sticky overflow flag and ends the run.
// -----------------------------------------------------------------------------
module seq_checker #(
   parameter int WIDTH = 5,
   parameter int LEN_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] cfg_first,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [LEN_W-1:0] err_count,
   output logic [LEN_W-1:0] beats,
   output logic [LEN_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_data,
   output logic             overflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONES  = {LEN_W{1'b1}};
   localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] DATA_ONES = {WIDTH{1'b1}};

   // Saturating increment: the error counter sticks at all-ones.
   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] val);
      logic [LEN_W-1:0] res;
      if (val == LEN_ONES) begin
         res = val;
      end else begin
         res = val + LEN_W'(1);
      end
      return res;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
   logic [LEN_W-1:0] beats_q, beats_d;
   logic [LEN_W-1:0] err_count_q, err_count_d;
   logic [LEN_W-1:0] first_err_idx_q, first_err_idx_d;
   logic [WIDTH-1:0] first_err_data_q, first_err_data_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             in_ready_s;
   logic             accept_s;

   // Ready depends only on state and start so a start cycle never consumes a beat.
   always_comb begin
      in_ready_s = (state_q == ST_RUN) && !start;
      accept_s   = in_valid && in_ready_s;
   end

   // Next-state, run statistics and registered status flags.
   always_comb begin
      state_d          = state_q;
      expected_d       = expected_q;
      cfg_len_d        = cfg_len_q;
      beats_d          = beats_q;
      err_count_d      = err_count_q;
      first_err_idx_d  = first_err_idx_q;
      first_err_data_d = first_err_data_q;
      overflow_d       = overflow_q;

      if (start) begin
         // Start (from any state) reloads the configuration and clears stats.
         cfg_len_d        = cfg_len;
         expected_d       = cfg_first;
         beats_d          = LEN_ZERO;
         err_count_d      = LEN_ZERO;
         first_err_idx_d  = LEN_ZERO;
         first_err_data_d = DATA_ZERO;
         overflow_d       = 1'b0;
         if (cfg_len != LEN_ZERO) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_DONE;
         end
      end else if (accept_s) begin
         beats_d    = beats_q + LEN_W'(1);
         expected_d = expected_q + WIDTH'(1);

         if (in_data != expected_q) begin
            err_count_d = sat_inc(err_count_q);
            // Capture index and data only on the first mismatch of the run.
            if (err_count_q == LEN_ZERO) begin
               first_err_idx_d  = beats_q;
               first_err_data_d = in_data;
            end else begin
               first_err_idx_d  = first_err_idx_q;
               first_err_data_d = first_err_data_q;
            end
         end else begin
            err_count_d = err_count_q;
         end

`ifdef SEQ_CHECKER_WRAP_EN
         overflow_d = 1'b0;
         if (beats_d == cfg_len_q) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_RUN;
         end
`else
         // The sequence cannot continue past the top value: end the run here.
         if (expected_q == DATA_ONES) begin
            overflow_d = 1'b1;
            state_d    = ST_DONE;
         end else if (beats_d == cfg_len_q) begin
            overflow_d = overflow_q;
            state_d    = ST_DONE;
         end else begin
            overflow_d = overflow_q;
            state_d    = ST_RUN;
         end
`endif
      end else begin
         state_d = state_q;
      end

      busy_d  = (state_d == ST_RUN);
      done_d  = (state_d == ST_DONE);
      error_d = (err_count_d != LEN_ZERO);
   end

   // State and statistics registers; reset wins over start and accept.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         expected_q       <= DATA_ZERO;
         cfg_len_q        <= LEN_ZERO;
         beats_q          <= LEN_ZERO;
         err_count_q      <= LEN_ZERO;
         first_err_idx_q  <= LEN_ZERO;
         first_err_data_q <= DATA_ZERO;
         overflow_q       <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         error_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         expected_q       <= expected_d;
         cfg_len_q        <= cfg_len_d;
         beats_q          <= beats_d;
         err_count_q      <= err_count_d;
         first_err_idx_q  <= first_err_idx_d;
         first_err_data_q <= first_err_data_d;
         overflow_q       <= overflow_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         error_q          <= error_d;
      end
   end

   assign in_ready       = in_ready_s;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign err_count      = err_count_q;
   assign beats          = beats_q;
   assign first_err_idx  = first_err_idx_q;
   assign first_err_data = first_err_data_q;
   assign overflow       = overflow_q;

endmodule
